// File: rtl/xor16_descrambler.sv
// xor16_descrambler
// Receive-side descrambler for a 16-bit XOR stream scrambler. Each accepted
// word is XORed with a 16-bit Fibonacci LFSR keystream. The keystream advances
// only when a word is accepted, so backpressure never desynchronises it from the
// transmit side. A single registered output stage sits behind a valid/ready
// handshake. When the consumer holds out_ready high, the block passes one word
// per cycle.
module xor16_descrambler #(
    parameter int                 WIDTH    = 16,
    parameter logic [WIDTH-1:0]   ZERO_SUB = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              seed_load,
    input  logic [WIDTH-1:0]  seed,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              locked,
    output logic [WIDTH-1:0]  word_count
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mode_t;

    // One Fibonacci LFSR step with taps 16,14,13,11. These taps give a
    // maximal-length sequence, so a non-zero state never reaches zero.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

    // A zero seed would lock the LFSR at zero, so it is replaced by ZERO_SUB.
    function automatic logic [15:0] seed_fix(input logic [15:0] s);
        return (s == 16'h0000) ? ZERO_SUB : s;
    endfunction

    mode_t             r_mode;
    mode_t             w_mode_next;
    logic [WIDTH-1:0]  r_lfsr;
    logic [WIDTH-1:0]  r_out_data;
    logic              r_out_valid;
    logic [WIDTH-1:0]  r_word_count;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_drain;

    // Handshake decode. Accept needs a seeded block, no reseed in this cycle,
    // and either an empty output stage or one that drains in this cycle.
    always_comb begin
        w_in_ready = 1'b0;
        w_accept   = 1'b0;
        w_drain    = 1'b0;
        if (r_mode == ST_RUN) begin
            w_in_ready = ~seed_load & (~r_out_valid | out_ready);
        end else begin
            w_in_ready = 1'b0;
        end
        w_accept = in_valid & w_in_ready;
        w_drain  = r_out_valid & out_ready;
    end

    // Next mode. A seed load always leads to RUN. Reset back to IDLE is
    // handled in the state register.
    always_comb begin
        w_mode_next = r_mode;
        case (r_mode)
            ST_IDLE: begin
                if (seed_load) begin
                    w_mode_next = ST_RUN;
                end else begin
                    w_mode_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                w_mode_next = ST_RUN;
            end
            default: begin
                w_mode_next = ST_IDLE;
            end
        endcase
    end

    // Mode register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode <= ST_IDLE;
        end else begin
            r_mode <= w_mode_next;
        end
    end

    // Keystream, output stage and word counter. A seed load overrides any
    // accept or drain in the same cycle and flushes the held word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr       <= 16'h0000;
            r_out_data   <= 16'h0000;
            r_out_valid  <= 1'b0;
            r_word_count <= 16'h0000;
        end else if (seed_load) begin
            r_lfsr       <= seed_fix(seed);
            r_out_valid  <= 1'b0;
            r_word_count <= 16'h0000;
        end else if (w_accept) begin
            r_out_data   <= in_data ^ r_lfsr;
            r_out_valid  <= 1'b1;
            r_lfsr       <= lfsr_step(r_lfsr);
            r_word_count <= r_word_count + 16'd1;
        end else if (w_drain) begin
            r_out_valid  <= 1'b0;
        end else begin
            r_out_valid  <= r_out_valid;
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign locked     = (r_mode == ST_RUN);
    assign word_count = r_word_count;

endmodule

// File: tb/tb_xor16_descrambler.sv
// Bench for xor16_descrambler. The stimulus process pushes the expected output
// words into a queue. A separate monitor pops one entry per output handshake
// and compares it with out_data.
module tb_xor16_descrambler;

    logic        clk = 1'b0;
    logic        reset;
    logic        seed_load;
    logic [15:0] seed;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        locked;
    logic [15:0] word_count;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_q[$];
    bit          bp_random = 1'b0;

    xor16_descrambler dut (
        .clk        (clk),
        .reset      (reset),
        .seed_load  (seed_load),
        .seed       (seed),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .locked     (locked),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] tx_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor. A word is consumed at the next posedge when valid and ready are
    // both high. Sampling on the negedge keeps the check away from that edge.
    always @(negedge clk) begin
        if (!reset && !seed_load && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h expected none", out_data);
            end else begin
                check("out_data", {16'd0, out_data}, {16'd0, exp_q.pop_front()});
            end
        end
    end

    // Hold the word until it is accepted. Push the expected result at the
    // accepting edge. Give up after 200 cycles.
    task automatic send(input logic [15:0] d, input logic [15:0] e);
        int  n;
        bit  ok;
        n  = 0;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        while (!ok && n < 200) begin
            if (bp_random) out_ready = ($urandom_range(0, 15) != 0);
            #1;
            if (in_ready) begin
                exp_q.push_back(e);
                ok = 1'b1;
            end
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: word %h not accepted, expected accept", d);
        end
    endtask

    task automatic do_seed(input logic [15:0] s);
        seed_load = 1'b1;
        seed      = s;
        @(posedge clk); #1;
        seed_load = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] tx;
        logic [15:0] w;
        reset     = 1'b1;
        seed_load = 1'b0;
        seed      = 16'h0000;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_word_count", word_count, 0);
        check("rst_locked", locked, 0);
        check("rst_in_ready", in_ready, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // 1: seed 1, three words back to back
        do_seed(16'h0001);
        check("t1_locked", locked, 1);
        send(16'h1234, 16'h1235);
        send(16'h1234, 16'h1236);
        send(16'h0000, 16'h0004);
        drain();
        check("t1_word_count", word_count, 3);

        // 2: zero seed is substituted
        do_seed(16'h0000);
        send(16'h0000, 16'hACE1);
        drain();
        check("t2_locked", locked, 1);
        check("t2_word_count", word_count, 1);

        // 3: backpressure holds output, second word waits
        do_seed(16'h0001);
        out_ready = 1'b0;
        send(16'hAAAA, 16'hAAAB);
        in_valid = 1'b1;
        in_data  = 16'h5555;
        repeat (3) begin
            check("t3_in_ready_low", in_ready, 0);
            check("t3_out_data_held", out_data, 16'hAAAB);
            check("t3_out_valid", out_valid, 1);
            @(posedge clk); #1;
        end
        check("t3_count_held", word_count, 1);
        out_ready = 1'b1;
        send(16'h5555, 16'h5557);
        drain();

        // 4: feedback bit set from tap 10
        do_seed(16'h0400);
        send(16'h0000, 16'h0400);
        send(16'h0000, 16'h0801);
        drain();

        // 5: reset with a held word
        do_seed(16'h0001);
        out_ready = 1'b0;
        send(16'h1111, 16'h1110);
        check("t5_pre_valid", out_valid, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        check("t5_out_valid", out_valid, 0);
        check("t5_locked", locked, 0);
        check("t5_word_count", word_count, 0);
        check("t5_in_ready", in_ready, 0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h7777;
        repeat (3) begin
            check("t5_idle_in_ready", in_ready, 0);
            @(posedge clk); #1;
            check("t5_idle_out_valid", out_valid, 0);
        end
        in_valid = 1'b0;
        check("t5_idle_count", word_count, 0);

        // 6: loopback against a transmit-side model with random backpressure
        do_seed(16'hBEEF);
        tx = 16'hBEEF;
        bp_random = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            w = 16'($urandom);
            send(w ^ tx, w);
            tx = tx_step(tx);
        end
        bp_random = 1'b0;
        out_ready = 1'b1;
        drain();
        check("t6_word_count_wrap", word_count, 16'd4464);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
